// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: redirect input, instruction-memory request/response, and decode hand-off.
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  // Environment view: branch resolution, instruction memory and decode.
  modport master (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

  // Fetch-stage view.
  modport slave (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps an in-order queue of outstanding and
// returned fetches, delivers them to decode in program order and squashes wrong-path data.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  ifetch_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic          head_valid;
  logic          pop;
  logic          accept;
  logic          fill;
  logic [CW-1:0] live;
  logic [SW-1:0] stale;
  logic          unused_rpc;

  assign unused_rpc = ^bus.redirect_pc[1:0];

  // Handshake and delivery decode from the current queue state.
  assign head_valid         = (cnt_q != '0) && filled_q[head_q];
  assign pop                = head_valid && bus.id_ready;
  assign live               = cnt_q - CW'(pop);
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (drop_q == '0) && (live < DEPTH_C);
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign fill               = bus.imem_rsp_valid && (drop_q == '0) && (pend_q != '0)
                              && !bus.redirect_valid;
  assign stale              = SW'(pend_q) + SW'(drop_q);

  assign bus.imem_req_addr = pc_q;
  assign bus.id_valid      = head_valid;
  assign bus.id_instr      = head_valid ? instr_mem[head_q] : 32'h0;
  assign bus.id_pc         = head_valid ? addr_mem[head_q]  : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      cnt_d    = '0;
      pend_d   = '0;
      filled_d = '0;
      // A response landing in the redirect cycle belongs to the squashed path.
      if (bus.imem_rsp_valid && (stale != '0)) drop_d = CW'(stale - SW'(1));
      else                                     drop_d = CW'(stale);
    end else begin
      if (accept) begin
        pc_d             = pc_q + 32'd4;
        tail_d           = tail_q + PW'(1);
        filled_d[tail_q] = 1'b0;
      end
      if (pop) head_d = head_q + PW'(1);
      if (fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      cnt_d  = cnt_q + CW'(accept) - CW'(pop);
      pend_d = pend_q + CW'(accept) - CW'(fill);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // Payload storage is reset-free: every read is qualified by the filled flags.
  always_ff @(posedge clk) begin
    if (accept) addr_mem[tail_q]  <= pc_q;
    if (fill)   instr_mem[fill_q] <= bus.imem_rsp_data;
  end
endmodule
